// File: rtl/step_pkg.sv
// Shared types and default widths for the step move controller slice.
//   state_t   : sequencer states
//   DEF_CNT_W : default step count width
//   DEF_PER_W : default period width (clk cycles)
package step_pkg;

  localparam int unsigned DEF_CNT_W = 16;
  localparam int unsigned DEF_PER_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE_HI,
    PULSE_LO,
    DONE
  } state_t;

endpackage

// File: rtl/step_move_controller_if.sv
// Move command channel (valid/ready) between host logic and the controller.
//   cmd_valid  : command present (master -> slave)
//   cmd_ready  : controller can accept (slave -> master)
//   cmd_dir    : 1 = forward
//   cmd_half   : 1 = half-step mode
//   cmd_steps  : number of step pulses
//   cmd_period : cruise period in clk cycles
interface step_move_controller_if #(
  parameter int unsigned CNT_W = step_pkg::DEF_CNT_W,
  parameter int unsigned PER_W = step_pkg::DEF_PER_W
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir;
  logic             cmd_half;
  logic [CNT_W-1:0] cmd_steps;
  logic [PER_W-1:0] cmd_period;

  modport master (
    output cmd_valid, cmd_dir, cmd_half, cmd_steps, cmd_period,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_half, cmd_steps, cmd_period,
    output cmd_ready
  );

endinterface

// File: rtl/step_ramp_gen.sv
// Trapezoidal speed ramp: holds the current step period, the clamped cruise
// target and the number of acceleration steps taken (mirrored on decel).
//   load       : capture a new command (cmd_period) and reset the ramp
//   update     : one step period has elapsed; advance the ramp
//   steps_left : pulses still to issue, decides accel/cruise/decel
//   cur_per    : period to use for the next step, clk cycles
module step_ramp_gen
  import step_pkg::*;
#(
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter int unsigned PER_W     = DEF_PER_W,
  parameter int unsigned PULSE_W   = 8,
  parameter int unsigned START_PER = 4000,
  parameter int unsigned ACC_DEC   = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [PER_W-1:0] cmd_period,
  input  logic             update,
  input  logic [CNT_W-1:0] steps_left,
  output logic [PER_W-1:0] cur_per
);

  // One extra bit so cur_per + ACC_DEC never wraps before the clamp.
  localparam int unsigned   EW      = PER_W + 1;
  localparam logic [EW-1:0] START_E = EW'(START_PER);
  localparam logic [EW-1:0] STEP_E  = EW'(ACC_DEC);
  localparam logic [EW-1:0] MIN_E   = EW'(2 * PULSE_W);

  logic [PER_W-1:0] tgt;
  logic [CNT_W-1:0] ramp_cnt;
  logic [EW-1:0]    tgt_ld_c;
  logic [EW-1:0]    up_c;
  logic [EW-1:0]    dn_c;

  // Candidate periods: clamped target, slowed-down and sped-up values.
  always_comb begin
    tgt_ld_c = (EW'(cmd_period) > MIN_E) ? EW'(cmd_period) : MIN_E;
    up_c     = EW'(cur_per) + STEP_E;
    if (up_c > START_E) begin
      up_c = START_E;
    end
    dn_c = (EW'(cur_per) >= EW'(tgt) + STEP_E) ? EW'(cur_per) - STEP_E : EW'(tgt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_per  <= '0;
      tgt      <= '0;
      ramp_cnt <= '0;
    end else if (load) begin
      tgt      <= PER_W'(tgt_ld_c);
      cur_per  <= (tgt_ld_c < START_E) ? PER_W'(START_E) : PER_W'(tgt_ld_c);
      ramp_cnt <= '0;
    end else if (update) begin
      // Decel once the remaining pulses no longer cover the accel distance.
      if (steps_left <= ramp_cnt) begin
        cur_per <= PER_W'(up_c);
        if (ramp_cnt != '0) begin
          ramp_cnt <= ramp_cnt - CNT_W'(1);
        end
      end else if (cur_per > tgt) begin
        cur_per <= PER_W'(dn_c);
        if (ramp_cnt != '1) begin
          ramp_cnt <= ramp_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/step_move_controller.sv
// Motion sequencer for one unipolar step driver: accepts move commands and
// emits step/dir/en/half_step with a linear trapezoidal speed ramp.
//   clk, rst_n  : clock, async active-low reset
//   cmd         : move command channel (slave side)
//   en_hold     : keep en asserted after a move
//   abort       : stop the move at the next safe point
//   step        : step pulse, driver acts on rising edge
//   dir         : direction, 1 = forward
//   en          : driver enable
//   half_step   : half-step mode
//   busy        : high from acceptance until DONE exits
//   done        : one-cycle pulse at end of move
//   steps_left  : pulses still to issue
module step_move_controller
  import step_pkg::*;
#(
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter int unsigned PER_W     = DEF_PER_W,
  parameter int unsigned PULSE_W   = 8,
  parameter int unsigned SETUP_CYC = 4,
  parameter int unsigned START_PER = 4000,
  parameter int unsigned ACC_DEC   = 40
) (
  input  logic                  clk,
  input  logic                  rst_n,
  step_move_controller_if.slave cmd,
  input  logic                  en_hold,
  input  logic                  abort,
  output logic                  step,
  output logic                  dir,
  output logic                  en,
  output logic                  half_step,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      steps_left
);

  localparam int unsigned      TMR_W    = PER_W;
  localparam logic [TMR_W-1:0] SETUP_LD = TMR_W'(SETUP_CYC - 1);
  localparam logic [TMR_W-1:0] HI_LD    = TMR_W'(PULSE_W - 1);

  state_t           state;
  logic [TMR_W-1:0] tmr;
  logic             abort_pend;
  logic             moved;
  logic [PER_W-1:0] cur_per;

  logic             accept_c;
  logic             tmr_zero_c;
  logic             ramp_upd_c;
  logic [TMR_W-1:0] lo_ld_c;

  assign accept_c   = (state == IDLE) && cmd.cmd_valid && cmd.cmd_ready;
  assign tmr_zero_c = (tmr == '0);
  // Ramp advances once per completed step period (not on an aborted one).
  assign ramp_upd_c = (state == PULSE_LO) && tmr_zero_c && !abort;
  // Low time makes the rise-to-rise period equal cur_per exactly.
  assign lo_ld_c    = TMR_W'(cur_per) - TMR_W'(PULSE_W) - TMR_W'(1);

  step_ramp_gen #(
    .CNT_W     (CNT_W),
    .PER_W     (PER_W),
    .PULSE_W   (PULSE_W),
    .START_PER (START_PER),
    .ACC_DEC   (ACC_DEC)
  ) u_ramp (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (accept_c),
    .cmd_period (cmd.cmd_period),
    .update     (ramp_upd_c),
    .steps_left (steps_left),
    .cur_per    (cur_per)
  );

  // Sequencer: state, phase timer and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      tmr           <= '0;
      abort_pend    <= 1'b0;
      moved         <= 1'b0;
      step          <= 1'b0;
      dir           <= 1'b0;
      en            <= 1'b0;
      half_step     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      steps_left    <= '0;
      cmd.cmd_ready <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          cmd.cmd_ready <= 1'b1;
          if (moved) begin
            en <= en_hold;
          end
          if (accept_c) begin
            cmd.cmd_ready <= 1'b0;
            dir           <= cmd.cmd_dir;
            half_step     <= cmd.cmd_half;
            steps_left    <= cmd.cmd_steps;
            en            <= 1'b1;
            busy          <= 1'b1;
            abort_pend    <= 1'b0;
            tmr           <= SETUP_LD;
            if (cmd.cmd_steps == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= SETUP;
            end
          end
        end

        SETUP: begin
          if (abort) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (tmr_zero_c) begin
            state      <= PULSE_HI;
            step       <= 1'b1;
            steps_left <= steps_left - CNT_W'(1);
            tmr        <= HI_LD;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end

        // An abort here is remembered so the pulse keeps its full width.
        PULSE_HI: begin
          if (abort) begin
            abort_pend <= 1'b1;
          end
          if (tmr_zero_c) begin
            step <= 1'b0;
            if (abort || abort_pend) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= PULSE_LO;
              tmr   <= lo_ld_c;
            end
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end

        PULSE_LO: begin
          if (abort) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (tmr_zero_c) begin
            if (steps_left == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state      <= PULSE_HI;
              step       <= 1'b1;
              steps_left <= steps_left - CNT_W'(1);
              tmr        <= HI_LD;
            end
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end

        DONE: begin
          state         <= IDLE;
          busy          <= 1'b0;
          cmd.cmd_ready <= 1'b1;
          en            <= en_hold;
          moved         <= 1'b1;
          abort_pend    <= 1'b0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
